post_accum_stage: RTL

- Output/accumulate stage that sits directly around the POST-type adder/subtractor in the DSP48A1 datapath.
- Selects the X and Z operands and the carry-in, and drives them to the post-adder.
- Registers the adder's sum and carry into P and CARRYOUT, and feeds P back for accumulation.
- Drives the PCOUT cascade and keeps a sticky signed-overflow flag.

---
 rtl/post_accum_stage_if.sv | 34 +++
 rtl/post_accum_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/post_accum_stage_if.sv
// Post-adder operand/result bus.
// The accumulate stage (master) drives the operands, carry-in and add/subtract
// control into the shared POST adder/subtractor. The adder (slave) returns the
// result and its carry/borrow out.
interface post_accum_stage_if #(
  parameter int DATA_WIDTH = 48
);

  logic [DATA_WIDTH-1:0] add_x;     // Z-mux result, adder x operand
  logic [DATA_WIDTH-1:0] add_y;     // X-mux result, adder y operand
  logic                  add_cin;   // carry-in
  logic                  add_sub;   // 1 = x - (y + cin), 0 = x + y + cin
  logic [DATA_WIDTH-1:0] add_z;     // adder result
  logic                  add_cout;  // carry (add) or borrow (subtract) out

  modport master (
    output add_x,
    output add_y,
    output add_cin,
    output add_sub,
    input  add_z,
    input  add_cout
  );

  modport slave (
    input  add_x,
    input  add_y,
    input  add_cin,
    input  add_sub,
    output add_z,
    output add_cout
  );

endinterface : post_accum_stage_if

// File: rtl/post_accum_stage.sv
// DSP48A1-style output/accumulate stage wrapped around the POST adder.
// Selects the X/Z operands and carry-in for the post-adder, registers its sum
// into P (with feedback for accumulation) and its carry into CARRYOUT, drives
// the PCOUT cascade and tracks a sticky signed-overflow flag.
module post_accum_stage #(
  parameter int DATA_WIDTH  = 48,
  parameter int OPMODEREG   = 1,
  parameter int CREG        = 1,
  parameter int CARRYINREG  = 1,
  parameter int CARRYOUTREG = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce_opmode,
  input  logic                    ce_c,
  input  logic                    ce_carryin,
  input  logic                    ce_p,
  input  logic                    ce_carryout,
  input  logic [7:0]              opmode,
  input  logic [35:0]             m,
  input  logic [DATA_WIDTH-1:0]   dab,
  input  logic [DATA_WIDTH-1:0]   c,
  input  logic [DATA_WIDTH-1:0]   pcin,
  post_accum_stage_if.master      add_bus,
  input  logic                    clr_ovf,
  output logic [DATA_WIDTH-1:0]   p,
  output logic [DATA_WIDTH-1:0]   pcout,
  output logic                    carryout,
  output logic                    ovf
);

  localparam int MW = 36;

  // Only the opmode fields this stage uses are kept; opmode[5] (carry-in)
  // has its own register and bits 4 and 6 have no function here.
  typedef struct packed {
    logic       sub;
    logic [1:0] z_sel;
    logic [1:0] x_sel;
  } opm_t;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } z_sel_e;

  opm_t                  opm_in;
  opm_t                  opm_q, opm_d;
  logic [DATA_WIDTH-1:0] c_q, c_d;
  logic                  ci_q, ci_d;
  logic [DATA_WIDTH-1:0] p_q, p_d;
  logic                  co_q, co_d;
  logic                  ovf_q, ovf_d;

  // Effective (registered or bypassed) control and operand values.
  opm_t                  opm;
  logic [DATA_WIDTH-1:0] cr;
  logic                  ci;

  logic [DATA_WIDTH-1:0] x_mux;
  logic [DATA_WIDTH-1:0] z_mux;
  logic                  ovf_det;

  logic                  unused_opmode_bits;
  assign unused_opmode_bits = ^{opmode[6], opmode[4]};

  assign opm_in = '{sub: opmode[7], z_sel: opmode[3:2], x_sel: opmode[1:0]};

  assign opm = (OPMODEREG  != 0) ? opm_q : opm_in;
  assign cr  = (CREG       != 0) ? c_q   : c;
  assign ci  = (CARRYINREG != 0) ? ci_q  : opmode[5];

  // X mux: operand added to (or subtracted from) the Z side.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    x_mux = '0;
    unique case (x_sel_e'(opm.x_sel))
      X_ZERO: x_mux = '0;
      X_M:    x_mux = {{(DATA_WIDTH-MW){1'b0}}, m};
      X_P:    x_mux = p_q;
      X_DAB:  x_mux = dab;
    endcase
  end

  // Z mux: the accumulator side of the post-adder.
  always_comb begin
    z_mux = '0;
    unique case (z_sel_e'(opm.z_sel))
      Z_ZERO: z_mux = '0;
      Z_PCIN: z_mux = pcin;
      Z_P:    z_mux = p_q;
      Z_C:    z_mux = cr;
    endcase
  end

  assign add_bus.add_x   = z_mux;
  assign add_bus.add_y   = x_mux;
  assign add_bus.add_cin = ci;
  assign add_bus.add_sub = opm.sub;

  // Signed overflow from operand and result signs: an add overflows when both
  // operands share a sign the result lacks; a subtract overflows when the
  // operands differ in sign and the result's sign differs from the minuend's.
  always_comb begin
    logic sx, sy, sz;
    sx      = add_bus.add_x[DATA_WIDTH-1];
    sy      = add_bus.add_y[DATA_WIDTH-1];
    sz      = add_bus.add_z[DATA_WIDTH-1];
    ovf_det = (opm.sub ? (sx != sy) : (sx == sy)) && (sz != sx);
  end

  // Next-state for every register: load when enabled, otherwise hold.
  always_comb begin
    opm_d = ce_opmode   ? opm_in           : opm_q;
    c_d   = ce_c        ? c                : c_q;
    ci_d  = ce_carryin  ? opmode[5]        : ci_q;
    p_d   = ce_p        ? add_bus.add_z    : p_q;
    co_d  = ce_carryout ? add_bus.add_cout : co_q;

    // A new overflow on this P update takes priority over a clear request.
    ovf_d = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (ce_p && ovf_det) begin
      ovf_d = 1'b1;
    end
  end

  // State registers, all cleared asynchronously by reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opm_q <= '0;
      c_q   <= '0;
      ci_q  <= 1'b0;
      p_q   <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      opm_q <= opm_d;
      c_q   <= c_d;
      ci_q  <= ci_d;
      p_q   <= p_d;
      co_q  <= co_d;
      ovf_q <= ovf_d;
    end
  end

  assign p        = p_q;
  assign pcout    = p_q;
  assign carryout = (CARRYOUTREG != 0) ? co_q : add_bus.add_cout;
  assign ovf      = ovf_q;

endmodule : post_accum_stage
